// File: rtl/sram_async_ctrl_pkg.sv
// Shared types and elaboration helpers for the asynchronous SRAM controller.
package sram_async_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_HOLD,
    ST_TURN,
    ST_RESP
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// Loadable down-counter; done is high while the current cycle is the last of the loaded span.
module sram_wait_cnt
  import sram_async_ctrl_pkg::*;
#(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt <= CW'(1));

endmodule

// File: rtl/sram_async_ctrl.sv
// Bus-to-async-SRAM bridge: each bus access becomes BUS_DW/PAD_DW pad beats, lowest first,
// with registered pad strobes, programmable waits and skipping of fully masked write beats.
module sram_async_ctrl
  import sram_async_ctrl_pkg::*;
#(
  parameter int BUS_DW   = 32,
  parameter int PAD_DW   = 16,
  parameter int PAD_AW   = 20,
  parameter int RD_WAIT  = 2,
  parameter int WR_WAIT  = 2,
  parameter int TURN_CYC = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_read,
  input  logic [31:0]           cmd_addr,
  input  logic [BUS_DW-1:0]     cmd_wdata,
  input  logic [BUS_DW/8-1:0]   cmd_wmask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [BUS_DW-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic [PAD_AW-1:0]     SRAM_ADDR_io,
  output logic                  SRAM_CSn_io,
  output logic                  SRAM_OEn_io,
  output logic                  SRAM_WRn_io,
  output logic [PAD_DW/8-1:0]   SRAM_BEn_io,
  output logic [PAD_DW-1:0]     SRAM_DATA_IN_io,
  input  logic [PAD_DW-1:0]     SRAM_DATA_OUT_io,
  output logic [PAD_DW-1:0]     SRAM_DATA_t
);

  localparam int BEATS  = BUS_DW / PAD_DW;
  localparam int LANES  = PAD_DW / 8;
  localparam int BMW    = BUS_DW / 8;
  localparam int OFFS   = $clog2(BMW);
  localparam int BEAT_W = $clog2(BEATS);
  localparam int BIW    = $clog2(BEATS + 1);
  localparam int CW     = $clog2(max3(RD_WAIT, WR_WAIT, TURN_CYC) + 1);

  if ((BUS_DW % PAD_DW) != 0 || (PAD_DW % 8) != 0 ||
      RD_WAIT < 1 || WR_WAIT < 1 || TURN_CYC < 1) begin : g_bad_param
    $error("sram_async_ctrl: illegal parameter combination");
  end

  function automatic logic [BIW-1:0] next_beat(input logic [BMW-1:0] m, input int start);
    next_beat = BIW'(BEATS);
    for (int i = BEATS - 1; i >= 0; i--) begin
      if (i >= start && (|m[i*LANES +: LANES])) next_beat = BIW'(i);
    end
  endfunction

  function automatic logic [PAD_DW-1:0] beat_data(input logic [BUS_DW-1:0] d,
                                                   input logic [BIW-1:0] b);
    beat_data = '0;
    for (int i = 0; i < BEATS; i++) if (BIW'(i) == b) beat_data = d[i*PAD_DW +: PAD_DW];
  endfunction

  function automatic logic [LANES-1:0] beat_ben(input logic [BMW-1:0] m,
                                                input logic [BIW-1:0] b);
    beat_ben = '1;
    for (int i = 0; i < BEATS; i++) if (BIW'(i) == b) beat_ben = ~m[i*LANES +: LANES];
  endfunction

  function automatic logic [BUS_DW-1:0] merge_beat(input logic [BUS_DW-1:0] d,
                                                    input logic [BIW-1:0] b,
                                                    input logic [PAD_DW-1:0] v);
    merge_beat = d;
    for (int i = 0; i < BEATS; i++) if (BIW'(i) == b) merge_beat[i*PAD_DW +: PAD_DW] = v;
  endfunction

  function automatic logic [PAD_AW-1:0] pad_word(input logic [31:0] word_base,
                                                 input logic [BIW-1:0] b);
    return PAD_AW'((64'(word_base) << BEAT_W) | 64'(b));
  endfunction

  state_t            state;
  logic              is_read;
  logic [31:0]       base;
  logic [BUS_DW-1:0] wdata_q;
  logic [BMW-1:0]    wmask_q;
  logic [BIW-1:0]    beat;

  logic              cnt_load, cnt_done;
  logic [CW-1:0]     cnt_val;
  logic              misaligned;
  logic              src_read;
  logic [31:0]       src_base;
  logic [BUS_DW-1:0] src_wdata;
  logic [BMW-1:0]    src_mask;
  logic [BIW-1:0]    nb;
  logic              last_beat, start_beat;

  // In IDLE the next beat is chosen straight from the command, afterwards from the latched copy.
  always_comb begin
    misaligned = (cmd_addr & 32'(BMW - 1)) != 32'd0;
    src_read   = (state == ST_IDLE) ? cmd_read  : is_read;
    src_base   = (state == ST_IDLE) ? (cmd_addr >> OFFS) : base;
    src_wdata  = (state == ST_IDLE) ? cmd_wdata : wdata_q;
    src_mask   = (state == ST_IDLE) ? cmd_wmask : wmask_q;
    nb         = next_beat(src_read ? {BMW{1'b1}} : src_mask,
                           (state == ST_IDLE) ? 0 : int'(beat) + 1);
    last_beat  = (nb == BIW'(BEATS));
    start_beat = !last_beat &&
                 ((state == ST_IDLE && cmd_valid && !misaligned) ||
                  (state == ST_TURN && cnt_done) ||
                  (state == ST_HOLD));
  end

  assign cnt_load = (state == ST_SETUP) || (state == ST_ACCESS && cnt_done && is_read);
  assign cnt_val  = (state == ST_SETUP) ? (is_read ? CW'(RD_WAIT) : CW'(WR_WAIT)) : CW'(TURN_CYC);

  sram_wait_cnt #(.CW(CW)) u_wait_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      cmd_ready       <= 1'b1;
      rsp_valid       <= 1'b0;
      rsp_rdata       <= '0;
      rsp_err         <= 1'b0;
      is_read         <= 1'b0;
      base            <= '0;
      wdata_q         <= '0;
      wmask_q         <= '0;
      beat            <= '0;
      SRAM_ADDR_io    <= '0;
      SRAM_CSn_io     <= 1'b1;
      SRAM_OEn_io     <= 1'b1;
      SRAM_WRn_io     <= 1'b1;
      SRAM_BEn_io     <= '1;
      SRAM_DATA_IN_io <= '0;
      SRAM_DATA_t     <= '1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            is_read   <= cmd_read;
            base      <= cmd_addr >> OFFS;
            wdata_q   <= cmd_wdata;
            wmask_q   <= cmd_wmask;
            rsp_rdata <= '0;
            rsp_err   <= misaligned;
            if (misaligned || last_beat) state <= ST_RESP;
          end
        end
        ST_SETUP: begin
          state <= ST_ACCESS;
          if (is_read) SRAM_OEn_io <= 1'b0;
          else         SRAM_WRn_io <= 1'b0;
        end
        ST_ACCESS: begin
          if (cnt_done) begin
            if (is_read) begin
              rsp_rdata   <= merge_beat(rsp_rdata, beat, SRAM_DATA_OUT_io);
              SRAM_CSn_io <= 1'b1;
              SRAM_OEn_io <= 1'b1;
              SRAM_BEn_io <= '1;
              state       <= ST_TURN;
            end else begin
              SRAM_WRn_io <= 1'b1;
              state       <= ST_HOLD;
            end
          end
        end
        ST_TURN: begin
          if (cnt_done && last_beat) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
          end
        end
        ST_HOLD: begin
          SRAM_DATA_t <= '1;
          if (last_beat) begin
            state           <= ST_RESP;
            rsp_valid       <= 1'b1;
            SRAM_CSn_io     <= 1'b1;
            SRAM_BEn_io     <= '1;
            SRAM_DATA_IN_io <= '0;
          end
        end
        ST_RESP: begin
          // Accesses with no pad activity arrive here with rsp_valid still low.
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (start_beat) begin
        state           <= ST_SETUP;
        beat            <= nb;
        SRAM_ADDR_io    <= pad_word(src_base, nb);
        SRAM_CSn_io     <= 1'b0;
        SRAM_OEn_io     <= 1'b1;
        SRAM_WRn_io     <= 1'b1;
        SRAM_BEn_io     <= src_read ? '0 : beat_ben(src_mask, nb);
        SRAM_DATA_t     <= src_read ? '1 : '0;
        SRAM_DATA_IN_io <= src_read ? '0 : beat_data(src_wdata, nb);
      end
    end
  end

endmodule
